// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the MCU data-bus arbiter slice.
package mcu_bus_pkg;

  localparam int unsigned BUS_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

endpackage

// File: rtl/bus_arbiter_mux.sv
// 2:1 data mux selecting between the two bus masters' write data.
module bus_arbiter_mux
  import mcu_bus_pkg::*;
#(
  parameter int unsigned DW = BUS_DW
) (
  input  logic [DW-1:0] In0,
  input  logic [DW-1:0] In1,
  input  logic          sel,
  output logic [DW-1:0] Out
);

  always_comb begin
    Out = sel ? In1 : In0;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded hold time and registered muxed data output.
module bus_arbiter
  import mcu_bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned DW       = BUS_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          sel,
  output logic [DW-1:0] bus_out,
  output logic          bus_valid
);

  localparam int unsigned    HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

  state_t          state;
  state_t          state_nx;
  logic [HW-1:0]   hold_cnt;
  logic            last;
  logic [DW-1:0]   mux_out;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (req0 && req1) state_nx = last ? ST_G0 : ST_G1;
        else if (req0)    state_nx = ST_G0;
        else if (req1)    state_nx = ST_G1;
      end
      ST_G0: begin
        if (!req0)                            state_nx = req1 ? ST_G1 : ST_IDLE;
        else if (req1 && hold_cnt == HOLD_LIM) state_nx = ST_G1;
      end
      ST_G1: begin
        if (!req1)                            state_nx = req0 ? ST_G0 : ST_IDLE;
        else if (req0 && hold_cnt == HOLD_LIM) state_nx = ST_G0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Grants are decoded from the next state so they become visible right after the sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      sel      <= 1'b0;
      hold_cnt <= '0;
      last     <= 1'b1;
    end else begin
      state <= state_nx;
      gnt0  <= (state_nx == ST_G0);
      gnt1  <= (state_nx == ST_G1);
      sel   <= (state_nx == ST_G1);
      if (state_nx != state || state_nx == ST_IDLE) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_LIM) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
      if (state_nx != state) begin
        if (state_nx == ST_G0) last <= 1'b0;
        if (state_nx == ST_G1) last <= 1'b1;
      end
    end
  end

  bus_arbiter_mux #(.DW(DW)) u_mux (
    .In0 (din0),
    .In1 (din1),
    .sel (sel),
    .Out (mux_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_out   <= '0;
      bus_valid <= 1'b0;
    end else begin
      bus_valid <= gnt0 | gnt1;
      if (gnt0 | gnt1) bus_out <= mux_out;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single master, handover, preemption, saturation, mid-op reset.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] din0, din1;
  logic       gnt0, gnt1, sel, bus_valid;
  logic [7:0] bus_out;
  logic       gnt0_b, gnt1_b, sel_b, bus_valid_b;
  logic [7:0] bus_out_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(4), .DW(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .din0      (din0),
    .din1      (din1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .bus_out   (bus_out),
    .bus_valid (bus_valid)
  );

  bus_arbiter #(.MAX_HOLD(1), .DW(8)) u_dut_h1 (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .din0      (din0),
    .din1      (din1),
    .gnt0      (gnt0_b),
    .gnt1      (gnt1_b),
    .sel       (sel_b),
    .bus_out   (bus_out_b),
    .bus_valid (bus_valid_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; din0 = 8'h11; din1 = 8'h22;

    // 1: reset holds everything low even with both requests pending
    #1;
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_sel", sel, 1'b0);
    check("rst_bus_out", bus_out, 8'h00);
    check("rst_valid", bus_valid, 1'b0);
    step();
    check("rst_edge_gnt0", gnt0, 1'b0);
    check("rst_edge_gnt1", gnt1, 1'b0);
    rst = 1'b0;
    step();
    check("first_tie_gnt0", gnt0, 1'b1);
    check("first_tie_gnt1", gnt1, 1'b0);

    req0 = 1'b0; req1 = 1'b0;
    step();
    check("release_gnt0", gnt0, 1'b0);
    check("release_valid", bus_valid, 1'b1);
    check("release_bus_out", bus_out, 8'h11);
    step();
    check("idle_valid", bus_valid, 1'b0);
    check("idle_hold_bus_out", bus_out, 8'h11);

    // 2: single master M1
    req1 = 1'b1; din1 = 8'hA5;
    step();
    check("m1_gnt1", gnt1, 1'b1);
    check("m1_gnt0", gnt0, 1'b0);
    check("m1_sel", sel, 1'b1);
    check("m1_valid_lat", bus_valid, 1'b0);
    step();
    check("m1_bus_out", bus_out, 8'hA5);
    check("m1_valid", bus_valid, 1'b1);
    step();
    check("m1_gnt1_hold", gnt1, 1'b1);
    check("m1_bus_out2", bus_out, 8'hA5);
    req1 = 1'b0;
    step();
    check("m1_rel_gnt1", gnt1, 1'b0);
    check("m1_rel_sel", sel, 1'b0);
    check("m1_rel_valid_lat", bus_valid, 1'b1);
    step();
    check("m1_rel_valid", bus_valid, 1'b0);
    check("m1_rel_bus_hold", bus_out, 8'hA5);

    // 3: handover without an idle cycle
    req0 = 1'b1; din0 = 8'h5A;
    step();
    check("ho_gnt0", gnt0, 1'b1);
    req1 = 1'b1;
    step();
    check("ho_gnt0_keep", gnt0, 1'b1);
    check("ho_gnt1_wait", gnt1, 1'b0);
    req0 = 1'b0; din1 = 8'h3C;
    step();
    check("ho_gnt1", gnt1, 1'b1);
    check("ho_gnt0_drop", gnt0, 1'b0);
    check("ho_bus_prev", bus_out, 8'h5A);
    check("ho_valid", bus_valid, 1'b1);
    step();
    check("ho_bus_new", bus_out, 8'h3C);
    check("ho_valid2", bus_valid, 1'b1);

    // 4: preemption with MAX_HOLD=4; M1 granted at k=0, so each 4-edge block alternates
    req0 = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      logic exp_g1;
      step();
      exp_g1 = (((k / 4) % 2) == 0);
      check($sformatf("pre_gnt1_k%0d", k), gnt1, exp_g1);
      check($sformatf("pre_gnt0_k%0d", k), gnt0, !exp_g1);
      check($sformatf("pre_excl_k%0d", k), gnt0 & gnt1, 1'b0);
    end

    // 5: lone owner is never forced off; competing request switches after saturation
    req1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("sat_gnt0_%0d", i), gnt0, 1'b1);
      check($sformatf("sat_gnt1_%0d", i), gnt1, 1'b0);
    end
    req1 = 1'b1;
    step();
    check("sat_switch_gnt1", gnt1, 1'b1);
    check("sat_switch_gnt0", gnt0, 1'b0);

    // 6: asynchronous reset mid-grant
    step();
    check("mid_gnt1", gnt1, 1'b1);
    check("mid_valid", bus_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt1", gnt1, 1'b0);
    check("mid_rst_sel", sel, 1'b0);
    check("mid_rst_valid", bus_valid, 1'b0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_gnt0", gnt0, 1'b1);
    check("post_rst_gnt1", gnt1, 1'b0);

    // 7: MAX_HOLD=1 instance alternates every edge while both request
    check("h1_first_gnt0", gnt0_b, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("h1_gnt1_%0d", i), gnt1_b, (i % 2) == 1);
      check($sformatf("h1_gnt0_%0d", i), gnt0_b, (i % 2) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
